// File: rtl/dpu_opnd_stage.sv
// Operand-fetch stage: RF read, writeback forwarding, busy scoreboard for
// RAW/WAW stalls, and a registered valid/ready packet toward execute.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef RF_DEPTH
`define RF_DEPTH 32
`endif

module dpu_opnd_stage #(
   parameter int CTRL_W = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      dec2opd_vld_i,
   output logic                      opd2dec_rdy_o,
   input  logic                      dec2opd_rs1_en_i,
   input  logic                      dec2opd_rs2_en_i,
   input  logic [`RF_ADDR_WIDTH-1:0] dec2opd_rs1_addr_i,
   input  logic [`RF_ADDR_WIDTH-1:0] dec2opd_rs2_addr_i,
   input  logic                      dec2opd_rd_en_i,
   input  logic [`RF_ADDR_WIDTH-1:0] dec2opd_rd_addr_i,
   input  logic [CTRL_W-1:0]         dec2opd_ctrl_i,
   output logic                      opd2rf_re1_o,
   output logic                      opd2rf_re2_o,
   output logic [`RF_ADDR_WIDTH-1:0] opd2rf_raddr1_o,
   output logic [`RF_ADDR_WIDTH-1:0] opd2rf_raddr2_o,
   input  logic [`XLEN-1:0]          rf2opd_rs1_i,
   input  logic [`XLEN-1:0]          rf2opd_rs2_i,
   input  logic                      wb_wr0_i,
   input  logic [`RF_ADDR_WIDTH-1:0] wb_waddr0_i,
   input  logic [`XLEN-1:0]          wb_wdata0_i,
   input  logic                      wb_wr1_i,
   input  logic [`RF_ADDR_WIDTH-1:0] wb_waddr1_i,
   input  logic [`XLEN-1:0]          wb_wdata1_i,
   output logic                      opd2exu_vld_o,
   input  logic                      exu2opd_rdy_i,
   output logic [`XLEN-1:0]          opd2exu_rs1_o,
   output logic [`XLEN-1:0]          opd2exu_rs2_o,
   output logic                      opd2exu_rd_en_o,
   output logic [`RF_ADDR_WIDTH-1:0] opd2exu_rd_addr_o,
   output logic [CTRL_W-1:0]         opd2exu_ctrl_o
);

   localparam int AW    = `RF_ADDR_WIDTH;
   localparam int XW    = `XLEN;
   localparam int DEPTH = `RF_DEPTH;

   // Writeback hit on a write port; x0 never hits since it is hardwired zero.
   function automatic logic wb_hit(input logic wr, input logic [AW-1:0] waddr,
                                   input logic [AW-1:0] a);
      return wr & (waddr == a) & (a != '0);
   endfunction

   // Port 1 beats port 0 because it is the RF's last-written value.
   function automatic logic [XW-1:0] resolve(input logic en, input logic [AW-1:0] a,
                                             input logic h0, input logic h1,
                                             input logic [XW-1:0] d0, input logic [XW-1:0] d1,
                                             input logic [XW-1:0] rf_data);
      if (!en || a == '0) return '0;
      else if (h1)        return d1;
      else if (h0)        return d0;
      else                return rf_data;
   endfunction

   logic [DEPTH-1:0]  busy_q, busy_d;
   logic              vld_q, vld_d;
   logic [XW-1:0]     rs1_q, rs1_d, rs2_q, rs2_d;
   logic              rd_en_q, rd_en_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   logic h0_rs1, h1_rs1, h0_rs2, h1_rs2, h0_rd, h1_rd;
   logic raw1, raw2, waw, space, issue;
   logic [XW-1:0] rs1_res, rs2_res;

   // RF read ports pass straight through from decode.
   assign opd2rf_re1_o    = dec2opd_vld_i & dec2opd_rs1_en_i;
   assign opd2rf_re2_o    = dec2opd_vld_i & dec2opd_rs2_en_i;
   assign opd2rf_raddr1_o = dec2opd_rs1_addr_i;
   assign opd2rf_raddr2_o = dec2opd_rs2_addr_i;

   // Hazard detection, forwarding and the accept decision.
   always_comb begin
      h0_rs1 = wb_hit(wb_wr0_i, wb_waddr0_i, dec2opd_rs1_addr_i);
      h1_rs1 = wb_hit(wb_wr1_i, wb_waddr1_i, dec2opd_rs1_addr_i);
      h0_rs2 = wb_hit(wb_wr0_i, wb_waddr0_i, dec2opd_rs2_addr_i);
      h1_rs2 = wb_hit(wb_wr1_i, wb_waddr1_i, dec2opd_rs2_addr_i);
      h0_rd  = wb_hit(wb_wr0_i, wb_waddr0_i, dec2opd_rd_addr_i);
      h1_rd  = wb_hit(wb_wr1_i, wb_waddr1_i, dec2opd_rd_addr_i);
      // A writeback landing this cycle releases the hazard (forwarded data).
      raw1 = dec2opd_rs1_en_i & (dec2opd_rs1_addr_i != '0) & busy_q[dec2opd_rs1_addr_i]
             & !(h0_rs1 | h1_rs1);
      raw2 = dec2opd_rs2_en_i & (dec2opd_rs2_addr_i != '0) & busy_q[dec2opd_rs2_addr_i]
             & !(h0_rs2 | h1_rs2);
      waw  = dec2opd_rd_en_i & (dec2opd_rd_addr_i != '0) & busy_q[dec2opd_rd_addr_i]
             & !(h0_rd | h1_rd);
      space         = !vld_q | exu2opd_rdy_i;
      opd2dec_rdy_o = space & !raw1 & !raw2 & !waw;
      issue         = dec2opd_vld_i & opd2dec_rdy_o;
      rs1_res = resolve(dec2opd_rs1_en_i, dec2opd_rs1_addr_i, h0_rs1, h1_rs1,
                        wb_wdata0_i, wb_wdata1_i, rf2opd_rs1_i);
      rs2_res = resolve(dec2opd_rs2_en_i, dec2opd_rs2_addr_i, h0_rs2, h1_rs2,
                        wb_wdata0_i, wb_wdata1_i, rf2opd_rs2_i);
   end

   // Scoreboard next state: clear on writeback, then set on issue (set wins).
   always_comb begin
      busy_d = busy_q;
      if (wb_wr0_i) busy_d[wb_waddr0_i] = 1'b0;
      if (wb_wr1_i) busy_d[wb_waddr1_i] = 1'b0;
      if (issue && dec2opd_rd_en_i && dec2opd_rd_addr_i != '0)
         busy_d[dec2opd_rd_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Output packet: load on issue, drop valid on accept, otherwise hold.
   always_comb begin
      vld_d     = vld_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      ctrl_d    = ctrl_q;
      if (issue) begin
         vld_d     = 1'b1;
         rs1_d     = rs1_res;
         rs2_d     = rs2_res;
         rd_en_d   = dec2opd_rd_en_i;
         rd_addr_d = dec2opd_rd_addr_i;
         ctrl_d    = dec2opd_ctrl_i;
      end else if (exu2opd_rdy_i) begin
         vld_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q    <= '0;
         vld_q     <= 1'b0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         ctrl_q    <= '0;
      end else begin
         busy_q    <= busy_d;
         vld_q     <= vld_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign opd2exu_vld_o     = vld_q;
   assign opd2exu_rs1_o     = rs1_q;
   assign opd2exu_rs2_o     = rs2_q;
   assign opd2exu_rd_en_o   = rd_en_q;
   assign opd2exu_rd_addr_o = rd_addr_q;
   assign opd2exu_ctrl_o    = ctrl_q;

endmodule
